redmule_tcdm_splitter: RTL and testbench
========================================

REDMULE_TCDM_SPLITTER -- requirements
Module: redmule_tcdm_splitter

Interface
REQ-001 SHALL have parameter DW, default 256: wide-side data width in bits, multiple of 32.
REQ-002 SHALL have parameter MP, default DW/32: number of 32-bit narrow TCDM ports.
REQ-003 SHALL have parameter STRIDE, default 4: byte address increment between adjacent narrow ports.
REQ-004 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have wide request ports in_req (in, 1), in_gnt (out, 1), in_add (in, 32), in_wen (in, 1, 1=read), in_be (in, DW/8), in_data (in, DW).
REQ-007 SHALL have wide response ports in_r_data (out, DW) and in_r_valid (out, 1).
REQ-008 SHALL have narrow request ports tcdm_req (out, MP), tcdm_gnt (in, MP), tcdm_add (out, MPx32), tcdm_wen (out, MP), tcdm_be (out, MPx4), tcdm_data (out, MPx32).
REQ-009 SHALL have narrow response ports tcdm_r_data (in, MPx32) and tcdm_r_valid (in, MP).
REQ-010 SHALL have port busy_o, out, 1: high while any transaction is pending or uncollected.

Function
REQ-011 SHALL drive tcdm_add[i] = in_add + i*STRIDE (mod 2^32), tcdm_be[i] = in_be[4i+3:4i], tcdm_data[i] = in_data[32i+31:32i] and tcdm_wen[i] = in_wen.
REQ-012 SHALL hold a per-port granted flag gdone_q[MP].
REQ-013 SHALL assert tcdm_req[i] = in_req & ~gdone_q[i], so each narrow port is requested exactly once per wide transaction.
REQ-014 SHALL set gdone_q[i] on tcdm_req[i] & tcdm_gnt[i].
REQ-015 SHALL assert in_gnt combinationally when in_req & &(gdone_q | (tcdm_req & tcdm_gnt)).
REQ-016 SHALL clear all gdone_q on the edge following in_gnt; grants arriving in different cycles SHALL be tolerated.
REQ-017 SHALL rely on the master holding in_req and all payload stable until in_gnt; the block does not register the payload.
REQ-018 SHALL accept one narrow response per port, returned exactly one cycle after that port's grant, for reads and writes alike.
REQ-019 SHALL capture tcdm_r_data[i] into rbuf_q[i] and set rdone_q[i] on tcdm_r_valid[i].
REQ-020 SHALL detect completion when &(rdone_q | tcdm_r_valid), selecting live data for ports responding in that cycle.
REQ-021 On completion SHALL load the assembled word into in_r_data and pulse in_r_valid high for exactly one cycle on the next cycle; wide response latency is 1 cycle after the last narrow response.
REQ-022 SHALL hold in_r_data stable until the next completion.
REQ-023 On a completion cycle SHALL set next rdone_q to 0; otherwise next rdone_q = rdone_q | tcdm_r_valid.
REQ-024 SHALL allow back-to-back wide transactions, with a new in_gnt every cycle when all tcdm_gnt are high.
REQ-025 SHALL drive busy_o = |gdone_q | |rdone_q | in_req | in_r_valid.
REQ-026 SHALL ignore tcdm_r_valid[i] when rdone_q[i] is already set (protocol error, covered by assertion).

Reset
REQ-027 On rst_ni low SHALL clear gdone_q, rdone_q, rbuf_q, in_r_valid and in_r_data to 0, effective immediately and independent of clk_i.
REQ-028 Reset mid-transaction SHALL discard all partial grant and response state; tcdm_req follows in_req again as soon as reset is released.

Structure
REQ-029 SHALL place default DW, narrow word width (32) and STRIDE constants in redmule_pkg.
REQ-030 SHALL use one sub-module, redmule_tcdm_resp_collector, which holds rbuf_q, rdone_q and the output register.
REQ-031 SHALL contain SVA assertions for REQ-017 and REQ-026 under the simulation-only guard.

Verification
REQ-032 SHALL pass this scenario: MP=8, all tcdm_gnt=1, read at in_add=0x1000 -> in_gnt in the same cycle; tcdm_add[7]=0x101C; in_r_valid 2 cycles later with word i = 0xA0+i.
REQ-033 SHALL pass this scenario: port 3 gnt delayed 3 cycles -> tcdm_req drops on the other ports after cycle 0; in_gnt at cycle 3; in_r_valid at cycle 5; no duplicate requests.
REQ-034 SHALL pass this scenario: 4 back-to-back reads with full grant -> 4 in_gnt in consecutive cycles; 4 consecutive in_r_valid pulses in order; data correct.
REQ-035 SHALL pass this scenario: write, in_be=0x0000_000F, MP=8 -> all 8 ports requested; port0 be=0xF, others be=0; one in_r_valid.
REQ-036 SHALL pass this scenario: rst_ni asserted with 5 of 8 ports granted -> gdone_q=0 and in_r_valid=0 immediately; after release the next request is granted afresh on all 8 ports.
REQ-037 SHALL pass this scenario: in_add=0xFFFF_FFF0, MP=8 -> tcdm_add[4]=0x0000_0000 (address wrap).

Source files
------------

// File: rtl/redmule_pkg.sv
// ----------------------------------------------------------------------------
// redmule_pkg
// Shared constants for the RedMulE TCDM splitter slice: the default wide data
// width, the width of one narrow TCDM word, and the default byte stride
// between adjacent narrow ports.
// ----------------------------------------------------------------------------
package redmule_pkg;

    localparam int unsigned DW_DEFAULT     = 256; // wide-side data width (bits)
    localparam int unsigned WORD_W         = 32;  // narrow TCDM word width (bits)
    localparam int unsigned BE_W           = WORD_W / 8;
    localparam int unsigned STRIDE_DEFAULT = 4;   // byte step between ports

endpackage : redmule_pkg

// File: rtl/redmule_tcdm_resp_collector.sv
// ----------------------------------------------------------------------------
// redmule_tcdm_resp_collector
// Gathers one response per narrow port (ports may answer in different
// cycles), then presents the assembled wide word with a one-cycle valid pulse
// on the cycle after the last narrow response arrives.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   tcdm_r_data     MP x 32-bit narrow response data
//   tcdm_r_valid    MP narrow response valids
//   in_r_data       assembled wide response, held until the next completion
//   in_r_valid      one-cycle pulse per completed wide transaction
//   rdone_o         per-port "response collected" flags (feeds busy)
// ----------------------------------------------------------------------------
module redmule_tcdm_resp_collector
    import redmule_pkg::*;
#(
    parameter int unsigned MP = DW_DEFAULT / WORD_W
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [MP*WORD_W-1:0] tcdm_r_data,
    input  logic [MP-1:0]        tcdm_r_valid,
    output logic [MP*WORD_W-1:0] in_r_data,
    output logic                 in_r_valid,
    output logic [MP-1:0]        rdone_o
);

    logic [MP-1:0]        rdone_q, rdone_d;
    logic [MP-1:0]        rvalid_live;
    logic [MP*WORD_W-1:0] rbuf_q, rbuf_d;
    logic [MP*WORD_W-1:0] r_data_q;
    logic                 r_valid_q;
    logic                 complete;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        // A repeat response on an already-collected port is dropped.
        rvalid_live = tcdm_r_valid & ~rdone_q;
        complete    = &(rdone_q | rvalid_live);
        // rbuf_d doubles as the assembled word: live data for ports answering
        // this cycle, buffered data for the ones that answered earlier.
        rbuf_d      = rbuf_q;
        for (int i = 0; i < int'(MP); i++) begin
            if (rvalid_live[i]) begin
                rbuf_d[i*WORD_W +: WORD_W] = tcdm_r_data[i*WORD_W +: WORD_W];
            end
        end
        rdone_d = complete ? '0 : (rdone_q | rvalid_live);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: rbuf_q is datapath storage, yet it is reset too so a reset always
    // leaves no stale response data visible on the wide side.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdone_q   <= '0;
            rbuf_q    <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            rdone_q   <= rdone_d;
            rbuf_q    <= rbuf_d;
            r_valid_q <= complete;
            if (complete) begin
                r_data_q <= rbuf_d;
            end
        end
    end

    assign in_r_data  = r_data_q;
    assign in_r_valid = r_valid_q;
    assign rdone_o    = rdone_q;

`ifndef SYNTHESIS
    // A port must not answer twice within one wide transaction.
    a_no_dup_resp : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (tcdm_r_valid & rdone_q) == '0
    ) else $error("duplicate narrow response on a collected port");
`endif

endmodule : redmule_tcdm_resp_collector

// File: rtl/redmule_tcdm_splitter.sv
// ----------------------------------------------------------------------------
// redmule_tcdm_splitter
// Splits one wide TCDM request into MP 32-bit narrow requests at consecutive
// addresses. Each narrow port is requested until it is granted once; the wide
// grant is issued in the cycle the last outstanding narrow grant arrives.
// Narrow responses are reassembled by redmule_tcdm_resp_collector.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   in_req/gnt/add/wen/be/data     wide request (in_wen = 1 means read)
//   in_r_data/in_r_valid           wide response
//   tcdm_req/gnt/add/wen/be/data   MP narrow requests, flattened
//   tcdm_r_data/tcdm_r_valid       MP narrow responses, flattened
//   busy_o                         any transaction pending or uncollected
// ----------------------------------------------------------------------------
module redmule_tcdm_splitter
    import redmule_pkg::*;
#(
    parameter int unsigned DW     = DW_DEFAULT,
    parameter int unsigned MP     = DW / WORD_W,
    parameter int unsigned STRIDE = STRIDE_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // wide side
    input  logic                 in_req,
    output logic                 in_gnt,
    input  logic [31:0]          in_add,
    input  logic                 in_wen,
    input  logic [DW/8-1:0]      in_be,
    input  logic [DW-1:0]        in_data,
    output logic [DW-1:0]        in_r_data,
    output logic                 in_r_valid,
    // narrow side
    output logic [MP-1:0]        tcdm_req,
    input  logic [MP-1:0]        tcdm_gnt,
    output logic [MP*WORD_W-1:0] tcdm_add,
    output logic [MP-1:0]        tcdm_wen,
    output logic [MP*BE_W-1:0]   tcdm_be,
    output logic [MP*WORD_W-1:0] tcdm_data,
    input  logic [MP*WORD_W-1:0] tcdm_r_data,
    input  logic [MP-1:0]        tcdm_r_valid,
    output logic                 busy_o
);

    logic [MP-1:0] gdone_q, gdone_d;
    logic [MP-1:0] granted_now;
    logic [MP-1:0] rdone;

    // Payload fan-out: the master holds it stable until in_gnt, so it is
    // passed through combinationally rather than registered.
    for (genvar i = 0; i < int'(MP); i++) begin : g_port
        assign tcdm_add[i*WORD_W +: WORD_W]  = in_add + 32'(i * STRIDE);
        assign tcdm_be[i*BE_W +: BE_W]       = in_be[i*BE_W +: BE_W];
        assign tcdm_data[i*WORD_W +: WORD_W] = in_data[i*WORD_W +: WORD_W];
    end
    assign tcdm_wen = {MP{in_wen}};

    // A port that has already been granted stays quiet for the rest of the
    // wide transaction, so it is never requested twice.
    assign tcdm_req    = {MP{in_req}} & ~gdone_q;
    assign granted_now = tcdm_req & tcdm_gnt;
    assign in_gnt      = in_req & (&(gdone_q | granted_now));

    always_comb begin
        gdone_d = in_gnt ? '0 : (gdone_q | granted_now);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gdone_q <= '0;
        end else begin
            gdone_q <= gdone_d;
        end
    end

    redmule_tcdm_resp_collector #(
        .MP (MP)
    ) u_resp (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tcdm_r_data  (tcdm_r_data),
        .tcdm_r_valid (tcdm_r_valid),
        .in_r_data    (in_r_data),
        .in_r_valid   (in_r_valid),
        .rdone_o      (rdone)
    );

    assign busy_o = (|gdone_q) | (|rdone) | in_req | in_r_valid;

`ifndef SYNTHESIS
    // The master may not withdraw or alter a request before it is granted.
    a_req_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (in_req && !in_gnt) |=> (in_req && $stable(in_add) && $stable(in_wen)
                                 && $stable(in_be) && $stable(in_data))
    ) else $error("wide request changed before grant");
`endif

endmodule : redmule_tcdm_splitter

// File: tb/tb_redmule_tcdm_splitter.sv
// ----------------------------------------------------------------------------
// tb_redmule_tcdm_splitter
// Directed bench for the default configuration (DW=256, MP=8, STRIDE=4).
// A small TCDM model answers every granted narrow port one cycle later with
// data ((addr - 0x1000) >> 2) + 0xA0, so a read at 0x1000 returns 0xA0 + i.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_redmule_tcdm_splitter;

    localparam int DW = 256;
    localparam int MP = 8;

    logic            clk_i;
    logic            rst_ni;
    logic            in_req;
    logic            in_gnt;
    logic [31:0]     in_add;
    logic            in_wen;
    logic [DW/8-1:0] in_be;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   in_r_data;
    logic            in_r_valid;
    logic [MP-1:0]   tcdm_req;
    logic [MP-1:0]   tcdm_gnt;
    logic [MP*32-1:0] tcdm_add;
    logic [MP-1:0]   tcdm_wen;
    logic [MP*4-1:0] tcdm_be;
    logic [MP*32-1:0] tcdm_data;
    logic [MP*32-1:0] tcdm_r_data;
    logic [MP-1:0]   tcdm_r_valid;
    logic            busy_o;

    int n_checks = 0;
    int n_fails  = 0;

    redmule_tcdm_splitter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_req       (in_req),
        .in_gnt       (in_gnt),
        .in_add       (in_add),
        .in_wen       (in_wen),
        .in_be        (in_be),
        .in_data      (in_data),
        .in_r_data    (in_r_data),
        .in_r_valid   (in_r_valid),
        .tcdm_req     (tcdm_req),
        .tcdm_gnt     (tcdm_gnt),
        .tcdm_add     (tcdm_add),
        .tcdm_wen     (tcdm_wen),
        .tcdm_be      (tcdm_be),
        .tcdm_data    (tcdm_data),
        .tcdm_r_data  (tcdm_r_data),
        .tcdm_r_valid (tcdm_r_valid),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // TCDM model: one response per granted port, exactly one cycle later.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcdm_r_valid <= '0;
            tcdm_r_data  <= '0;
        end else begin
            tcdm_r_valid <= tcdm_req & tcdm_gnt;
            for (int i = 0; i < MP; i++) begin
                tcdm_r_data[i*32 +: 32] <= ((tcdm_add[i*32 +: 32] - 32'h1000) >> 2) + 32'hA0;
            end
        end
    end

    function automatic logic [31:0] word_of(input logic [MP*32-1:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        in_req   = 1'b0;
        in_add   = '0;
        in_wen   = 1'b1;
        in_be    = '1;
        in_data  = '0;
        tcdm_gnt = '1;

        // ---- reset state ----
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_in_gnt",     256'(in_gnt), 256'(0));
        check("rst_in_r_valid", 256'(in_r_valid), 256'(0));
        check("rst_in_r_data",  in_r_data, 256'(0));
        check("rst_busy",       256'(busy_o), 256'(0));
        check("rst_tcdm_req",   256'(tcdm_req), 256'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---- full-grant read at 0x1000 ----
        @(negedge clk_i);
        in_req = 1'b1; in_add = 32'h1000; in_wen = 1'b1;
        #1;
        check("rd_gnt_same_cycle", 256'(in_gnt), 256'(1));
        check("rd_tcdm_req",       256'(tcdm_req), 256'(8'hFF));
        check("rd_add7",           256'(word_of(tcdm_add, 7)), 256'(32'h101C));
        @(negedge clk_i);
        in_req = 1'b0;
        #1;
        check("rd_no_early_valid", 256'(in_r_valid), 256'(0));
        @(negedge clk_i);
        #1;
        check("rd_valid", 256'(in_r_valid), 256'(1));
        for (int i = 0; i < MP; i++) begin
            check($sformatf("rd_word%0d", i), 256'(word_of(in_r_data, i)), 256'(32'hA0 + i));
        end
        @(negedge clk_i);
        #1;
        check("rd_valid_pulse", 256'(in_r_valid), 256'(0));
        check("rd_data_held",   256'(word_of(in_r_data, 0)), 256'(32'hA0));

        // ---- port 3 granted 3 cycles late, read at 0x1100 ----
        @(negedge clk_i);
        in_req = 1'b1; in_add = 32'h1100; tcdm_gnt = 8'hF7;
        #1;
        check("lag_c0_req", 256'(tcdm_req), 256'(8'hFF));
        check("lag_c0_gnt", 256'(in_gnt), 256'(0));
        @(negedge clk_i);
        #1;
        check("lag_c1_req",  256'(tcdm_req), 256'(8'h08));
        check("lag_c1_gnt",  256'(in_gnt), 256'(0));
        check("lag_c1_busy", 256'(busy_o), 256'(1));
        @(negedge clk_i);
        #1;
        check("lag_c2_req", 256'(tcdm_req), 256'(8'h08));
        check("lag_c2_gnt", 256'(in_gnt), 256'(0));
        @(negedge clk_i);
        tcdm_gnt = 8'hFF;
        #1;
        check("lag_c3_gnt", 256'(in_gnt), 256'(1));
        check("lag_c3_req", 256'(tcdm_req), 256'(8'h08));
        @(negedge clk_i);
        in_req = 1'b0;
        #1;
        check("lag_c4_valid", 256'(in_r_valid), 256'(0));
        @(negedge clk_i);
        #1;
        check("lag_c5_valid", 256'(in_r_valid), 256'(1));
        check("lag_word0",    256'(word_of(in_r_data, 0)), 256'(32'hE0));
        check("lag_word3",    256'(word_of(in_r_data, 3)), 256'(32'hE3));
        @(negedge clk_i);
        #1;
        check("lag_idle_busy", 256'(busy_o), 256'(0));

        // ---- 4 back-to-back reads at 0x1200, 0x1220, 0x1240, 0x1260 ----
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            in_req = (c < 4);
            if (c < 4) in_add = 32'h1200 + 32'(c * 32'h20);
            #1;
            if (c < 4) check($sformatf("b2b_gnt%0d", c), 256'(in_gnt), 256'(1));
            if (c >= 2 && c < 6) begin
                check($sformatf("b2b_valid%0d", c - 2), 256'(in_r_valid), 256'(1));
                check($sformatf("b2b_w0_%0d", c - 2), 256'(word_of(in_r_data, 0)),
                      256'(32'h120 + 32'(8 * (c - 2))));
                check($sformatf("b2b_w7_%0d", c - 2), 256'(word_of(in_r_data, 7)),
                      256'(32'h127 + 32'(8 * (c - 2))));
            end
            if (c == 6) check("b2b_valid_end", 256'(in_r_valid), 256'(0));
        end

        // ---- partial byte-enable write ----
        @(negedge clk_i);
        in_req = 1'b1; in_wen = 1'b0; in_add = 32'h2000;
        in_be = 32'h0000_000F;
        in_data = {8{32'hDEAD_0000}} ^ {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        #1;
        check("wr_req",     256'(tcdm_req), 256'(8'hFF));
        check("wr_gnt",     256'(in_gnt), 256'(1));
        check("wr_wen",     256'(tcdm_wen), 256'(8'h00));
        check("wr_be0",     256'(tcdm_be[3:0]), 256'(4'hF));
        check("wr_be_rest", 256'(tcdm_be[31:4]), 256'(0));
        check("wr_data1",   256'(word_of(tcdm_data, 1)), 256'(32'hDEAD_0001));
        @(negedge clk_i);
        in_req = 1'b0; in_wen = 1'b1; in_be = '1;
        #1;
        check("wr_no_early_valid", 256'(in_r_valid), 256'(0));
        @(negedge clk_i);
        #1;
        check("wr_valid", 256'(in_r_valid), 256'(1));
        @(negedge clk_i);
        #1;
        check("wr_single_valid", 256'(in_r_valid), 256'(0));

        // ---- reset with 5 of 8 ports granted ----
        @(negedge clk_i);
        in_req = 1'b1; in_add = 32'h1300; tcdm_gnt = 8'h1F;
        #1;
        check("prst_gnt", 256'(in_gnt), 256'(0));
        @(negedge clk_i);
        #1;
        check("prst_gdone", 256'(dut.gdone_q), 256'(8'h1F));
        check("prst_req",   256'(tcdm_req), 256'(8'hE0));
        @(negedge clk_i);
        #1;
        check("prst_rdone", 256'(dut.u_resp.rdone_q), 256'(8'h1F));
        #1;
        rst_ni = 1'b0; in_req = 1'b0; tcdm_gnt = 8'hFF;
        #1;
        check("prst_gdone_clr", 256'(dut.gdone_q), 256'(0));
        check("prst_rdone_clr", 256'(dut.u_resp.rdone_q), 256'(0));
        check("prst_valid_clr", 256'(in_r_valid), 256'(0));
        check("prst_data_clr",  in_r_data, 256'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        in_req = 1'b1; in_add = 32'h1000;
        #1;
        check("prst_fresh_req", 256'(tcdm_req), 256'(8'hFF));
        check("prst_fresh_gnt", 256'(in_gnt), 256'(1));
        @(negedge clk_i);
        in_req = 1'b0;
        @(negedge clk_i);
        #1;
        check("prst_fresh_valid", 256'(in_r_valid), 256'(1));
        check("prst_fresh_word5", 256'(word_of(in_r_data, 5)), 256'(32'hA5));

        // ---- address wrap ----
        @(negedge clk_i);
        in_req = 1'b1; in_add = 32'hFFFF_FFF0;
        #1;
        check("wrap_add3", 256'(word_of(tcdm_add, 3)), 256'(32'hFFFF_FFFC));
        check("wrap_add4", 256'(word_of(tcdm_add, 4)), 256'(32'h0000_0000));
        check("wrap_add7", 256'(word_of(tcdm_add, 7)), 256'(32'h0000_000C));
        check("wrap_gnt",  256'(in_gnt), 256'(1));
        @(negedge clk_i);
        in_req = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        check("final_idle", 256'(busy_o), 256'(0));

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule : tb_redmule_tcdm_splitter
